// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - write port and serial status bundle for uart_tx_fifo
interface uart_tx_fifo_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4
);
    logic [DATA_BITS-1:0]          dadoEntrada;
    logic                          dadoValido;
    logic                          dadoPronto;
    logic                          txSerial;
    logic                          txAtivo;
    logic                          txConcluido;
    logic [$clog2(FIFO_DEPTH):0]   fifoNivel;

    modport master (
        output dadoEntrada, dadoValido,
        input  dadoPronto, txSerial, txAtivo, txConcluido, fifoNivel
    );

    modport slave (
        input  dadoEntrada, dadoValido,
        output dadoPronto, txSerial, txAtivo, txConcluido, fifoNivel
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - parametrised UART transmitter fed by a small circular FIFO
module uart_tx_fifo #(
    parameter int CLOCKS_POR_BIT = 5209,
    parameter int DATA_BITS      = 8,
    parameter int PARITY         = 0,
    parameter int STOP_BITS      = 1,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic           clock,
    input  logic           reset_n,
    uart_tx_fifo_if.slave  bus
);
    localparam int CW = (CLOCKS_POR_BIT > 2) ? $clog2(CLOCKS_POR_BIT) : 1;
    localparam int BW = $clog2(DATA_BITS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam logic [CW-1:0] LAST_CLK  = CW'(CLOCKS_POR_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
    localparam logic          LAST_STOP = 1'(STOP_BITS - 1);
    localparam logic [LW-1:0] FULL_LVL  = LW'(FIFO_DEPTH);
    // Mode 3 (and anything else) falls back to no parity bit.
    localparam bit PAR_EN = (PARITY == 1) || (PARITY == 2);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]        r_wr_ptr;
    logic [PW-1:0]        r_rd_ptr;
    logic [LW-1:0]        r_count;

    state_t               r_state;
    logic [CW-1:0]        r_clk_cnt;
    logic [BW-1:0]        r_bit_idx;
    logic                 r_stop_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par;

    state_t               w_state_nx;
    logic [CW-1:0]        w_clk_nx;
    logic [BW-1:0]        w_bit_nx;
    logic                 w_stop_nx;
    logic [DATA_BITS-1:0] w_shift_nx;
    logic                 w_par_nx;
    logic                 w_tx;
    logic                 w_ativo;
    logic                 w_done;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_bit_end;
    logic [DATA_BITS-1:0] w_head;

    assign w_push = bus.dadoValido && (r_count != FULL_LVL);
    assign w_head = r_mem[r_rd_ptr];

    assign bus.dadoPronto  = (r_count != FULL_LVL);
    assign bus.fifoNivel   = r_count;
    assign bus.txSerial    = w_tx;
    assign bus.txAtivo     = w_ativo;
    assign bus.txConcluido = w_done;

    // FIFO storage; contents are meaningless after reset because the pointers clear.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.dadoEntrada;
        end
    end

    // FIFO pointers and occupancy; a simultaneous push and pop leaves the count alone.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + LW'(1);
                2'b01:   r_count <= r_count - LW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Transmitter state and frame-private registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_clk_cnt  <= '0;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_shift    <= '0;
            r_par      <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_clk_cnt  <= w_clk_nx;
            r_bit_idx  <= w_bit_nx;
            r_stop_idx <= w_stop_nx;
            r_shift    <= w_shift_nx;
            r_par      <= w_par_nx;
        end
    end

    // Next-state, bit timing and line outputs for the frame sequencer.
    always_comb begin
        w_state_nx = r_state;
        w_clk_nx   = r_clk_cnt;
        w_bit_nx   = r_bit_idx;
        w_stop_nx  = r_stop_idx;
        w_shift_nx = r_shift;
        w_par_nx   = r_par;
        w_tx       = 1'b1;
        w_ativo    = 1'b0;
        w_done     = 1'b0;
        w_pop      = 1'b0;
        w_bit_end  = (r_clk_cnt == LAST_CLK);

        case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    w_pop      = 1'b1;
                    w_shift_nx = w_head;
                    w_par_nx   = (PARITY == 1) ? ~^w_head : ^w_head;
                    w_clk_nx   = '0;
                    w_bit_nx   = '0;
                    w_stop_nx  = 1'b0;
                    w_state_nx = S_START;
                end
            end
            S_START: begin
                w_tx    = 1'b0;
                w_ativo = 1'b1;
                if (w_bit_end) begin
                    w_clk_nx   = '0;
                    w_state_nx = S_DATA;
                end else begin
                    w_clk_nx = r_clk_cnt + CW'(1);
                end
            end
            S_DATA: begin
                w_tx    = r_shift[0];
                w_ativo = 1'b1;
                if (w_bit_end) begin
                    w_clk_nx   = '0;
                    w_shift_nx = r_shift >> 1;
                    if (r_bit_idx == LAST_BIT) begin
                        w_state_nx = PAR_EN ? S_PARITY : S_STOP;
                    end else begin
                        w_bit_nx = r_bit_idx + BW'(1);
                    end
                end else begin
                    w_clk_nx = r_clk_cnt + CW'(1);
                end
            end
            S_PARITY: begin
                w_tx    = r_par;
                w_ativo = 1'b1;
                if (w_bit_end) begin
                    w_clk_nx   = '0;
                    w_state_nx = S_STOP;
                end else begin
                    w_clk_nx = r_clk_cnt + CW'(1);
                end
            end
            S_STOP: begin
                w_tx    = 1'b1;
                w_ativo = 1'b1;
                if (w_bit_end) begin
                    w_clk_nx = '0;
                    if (r_stop_idx == LAST_STOP) begin
                        w_done     = 1'b1;
                        w_state_nx = S_IDLE;
                    end else begin
                        w_stop_nx = 1'b1;
                    end
                end else begin
                    w_clk_nx = r_clk_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - randomized self-checking bench for uart_tx_fifo across three frame formats
module tb_uart_tx_fifo;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic clock = 1'b0;
    logic reset_n = 1'b1;
    always #5 clock = ~clock;

    logic [8:0] din  [3];
    logic       vin  [3];
    logic       o_tx [3];
    logic       o_at [3];
    logic       o_done [3];
    logic       o_rdy [3];
    logic [2:0] o_lvl [3];

    int n_cmp  = 0;
    int n_fail = 0;

    uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(DEPTH)) if0 ();
    uart_tx_fifo_if #(.DATA_BITS(7), .FIFO_DEPTH(DEPTH)) if1 ();
    uart_tx_fifo_if #(.DATA_BITS(7), .FIFO_DEPTH(DEPTH)) if2 ();

    assign if0.dadoEntrada = din[0][7:0];
    assign if1.dadoEntrada = din[1][6:0];
    assign if2.dadoEntrada = din[2][6:0];
    assign if0.dadoValido  = vin[0];
    assign if1.dadoValido  = vin[1];
    assign if2.dadoValido  = vin[2];
    assign o_tx[0] = if0.txSerial;    assign o_tx[1] = if1.txSerial;    assign o_tx[2] = if2.txSerial;
    assign o_at[0] = if0.txAtivo;     assign o_at[1] = if1.txAtivo;     assign o_at[2] = if2.txAtivo;
    assign o_done[0] = if0.txConcluido; assign o_done[1] = if1.txConcluido; assign o_done[2] = if2.txConcluido;
    assign o_rdy[0] = if0.dadoPronto; assign o_rdy[1] = if1.dadoPronto; assign o_rdy[2] = if2.dadoPronto;
    assign o_lvl[0] = if0.fifoNivel;  assign o_lvl[1] = if1.fifoNivel;  assign o_lvl[2] = if2.fifoNivel;

    uart_tx_fifo #(.CLOCKS_POR_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH))
        dut0 (.clock(clock), .reset_n(reset_n), .bus(if0));
    uart_tx_fifo #(.CLOCKS_POR_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(DEPTH))
        dut1 (.clock(clock), .reset_n(reset_n), .bus(if1));
    uart_tx_fifo #(.CLOCKS_POR_BIT(CPB), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(DEPTH))
        dut2 (.clock(clock), .reset_n(reset_n), .bus(if2));

    function automatic int db(int d);  return (d == 0) ? 8 : 7; endfunction
    function automatic int par(int d); return (d == 0) ? 0 : ((d == 1) ? 2 : 1); endfunction
    function automatic int sb(int d);  return (d == 0) ? 1 : 2; endfunction

    // Reference model: queued words plus the remaining per-clock line samples of the frame in flight.
    int unsigned fifo_q  [3][$];
    bit          frame_q [3][$];

    function automatic void build_frame(int d, int unsigned w);
        bit bits[$];
        bit p;
        p = 1'b0;
        bits.push_back(1'b0);
        for (int i = 0; i < db(d); i++) begin
            bits.push_back(w[i]);
            p ^= w[i];
        end
        if (par(d) == 2) bits.push_back(p);
        else if (par(d) == 1) bits.push_back(~p);
        for (int s = 0; s < sb(d); s++) bits.push_back(1'b1);
        foreach (bits[k]) repeat (CPB) frame_q[d].push_back(bits[k]);
    endfunction

    function automatic void model_step(int d);
        bit idle;
        int cnt;
        bit push;
        idle = (frame_q[d].size() == 0);
        cnt  = fifo_q[d].size();
        push = vin[d] && (cnt < DEPTH);
        if (!idle) void'(frame_q[d].pop_front());
        if (idle && cnt > 0) build_frame(d, fifo_q[d].pop_front());
        if (push) fifo_q[d].push_back(int'(din[d]) & ((1 << db(d)) - 1));
    endfunction

    always @(posedge clock) begin
        for (int d = 0; d < 3; d++) begin
            if (!reset_n) begin
                fifo_q[d].delete();
                frame_q[d].delete();
            end else begin
                model_step(d);
            end
        end
    end

    // {txSerial, txAtivo, txConcluido, dadoPronto, fifoNivel}
    function automatic logic [6:0] exp_vec(int d);
        int fs;
        int ls;
        fs = frame_q[d].size();
        ls = fifo_q[d].size();
        return {(fs != 0) ? frame_q[d][0] : 1'b1, fs != 0, fs == 1, ls != DEPTH, 3'(ls)};
    endfunction

    function automatic logic [6:0] obs_vec(int d);
        return {o_tx[d], o_at[d], o_done[d], o_rdy[d], o_lvl[d]};
    endfunction

    task automatic test_reset();
        #2 reset_n = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            n_cmp++;
            if (obs_vec(d) !== 7'b1001000) begin
                n_fail++;
                $display("FAIL reset_async dut%0d got=%b want=%b", d, obs_vec(d), 7'b1001000);
            end
        end
        for (int c = 0; c < 3; c++) begin
            @(posedge clock); @(negedge clock);
            for (int d = 0; d < 3; d++) begin
                n_cmp++;
                if (obs_vec(d) !== 7'b1001000) begin
                    n_fail++;
                    $display("FAIL reset_hold dut%0d got=%b want=%b", d, obs_vec(d), 7'b1001000);
                end
            end
        end
        reset_n = 1'b1;
    endtask

    task automatic test_basic_frame();
        logic [9:0] seq;
        int act[3], n_done[3], done_at[3];
        logic par_bit[3];
        seq = '0;
        for (int d = 0; d < 3; d++) begin act[d] = 0; n_done[d] = 0; done_at[d] = -1; par_bit[d] = 1'bx; end
        din[0] = 9'h0A5; din[1] = 9'h003; din[2] = 9'h003;
        for (int c = 0; c < 60; c++) begin
            for (int d = 0; d < 3; d++) vin[d] = (c == 0);
            @(posedge clock); @(negedge clock);
            if (c == 1) begin
                n_cmp++;
                if (o_tx[0] !== 1'b0 || o_at[0] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL basic_start_latency tx=%b ativo=%b want tx=0 ativo=1", o_tx[0], o_at[0]);
                end
            end
            for (int d = 0; d < 3; d++) begin
                n_cmp++;
                if (obs_vec(d) !== exp_vec(d)) begin
                    n_fail++;
                    $display("FAIL basic_line dut%0d t=%0t got=%b want=%b", d, $time, obs_vec(d), exp_vec(d));
                end
                if (o_at[d] === 1'b1) begin
                    if (d == 0 && act[d] % CPB == 0 && act[d] < 40) seq[act[d] / CPB] = o_tx[0];
                    if (act[d] == 32) par_bit[d] = o_tx[d];
                    if (o_done[d] === 1'b1) begin n_done[d]++; done_at[d] = act[d]; end
                    act[d]++;
                end
            end
        end
        for (int d = 0; d < 3; d++) vin[d] = 1'b0;
        n_cmp++;
        if (seq !== 10'b1101001010) begin n_fail++; $display("FAIL basic_bits got=%b want=%b", seq, 10'b1101001010); end
        for (int d = 0; d < 3; d++) begin
            n_cmp++;
            if (act[d] != ((d == 0) ? 40 : 44) || n_done[d] != 1 || done_at[d] != act[d] - 1) begin
                n_fail++;
                $display("FAIL frame_len dut%0d len=%0d dones=%0d done_at=%0d want len=%0d dones=1", d, act[d], n_done[d], done_at[d], (d == 0) ? 40 : 44);
            end
        end
        n_cmp++;
        if (par_bit[1] !== 1'b0) begin n_fail++; $display("FAIL even_parity got=%b want=0", par_bit[1]); end
        n_cmp++;
        if (par_bit[2] !== 1'b1) begin n_fail++; $display("FAIL odd_parity got=%b want=1", par_bit[2]); end
    endtask

    task automatic test_fill_drain();
        logic [8:0] words[3][5];
        int idx[3], n_done[3];
        bit acc[3];
        for (int d = 0; d < 3; d++) begin
            idx[d] = 0; n_done[d] = 0;
            for (int k = 0; k < 5; k++) words[d][k] = 9'($urandom);
        end
        for (int c = 0; c < 260; c++) begin
            for (int d = 0; d < 3; d++) begin
                vin[d] = (idx[d] < 5);
                din[d] = words[d][(idx[d] < 5) ? idx[d] : 0];
                acc[d] = vin[d] && (fifo_q[d].size() < DEPTH);
            end
            @(posedge clock); @(negedge clock);
            if (c == 1) begin
                n_cmp++;
                if (o_lvl[0] !== 3'd1) begin n_fail++; $display("FAIL push_pop_same_clock level=%0d want=1", o_lvl[0]); end
            end
            for (int d = 0; d < 3; d++) begin
                if (acc[d]) idx[d]++;
                if (o_done[d] === 1'b1) n_done[d]++;
                n_cmp++;
                if (obs_vec(d) !== exp_vec(d)) begin
                    n_fail++;
                    $display("FAIL fill_line dut%0d t=%0t got=%b want=%b", d, $time, obs_vec(d), exp_vec(d));
                end
            end
        end
        for (int d = 0; d < 3; d++) begin
            vin[d] = 1'b0;
            n_cmp++;
            if (n_done[d] != 5) begin n_fail++; $display("FAIL fill_frames dut%0d got=%0d want=5", d, n_done[d]); end
        end
    endtask

    task automatic test_full_ignore();
        int n_done[3];
        for (int d = 0; d < 3; d++) n_done[d] = 0;
        for (int c = 0; c < 240; c++) begin
            for (int d = 0; d < 3; d++) begin
                vin[d] = (c < 12);
                din[d] = 9'($urandom);
            end
            @(posedge clock); @(negedge clock);
            if (c == 11) begin
                n_cmp++;
                if (o_lvl[0] !== 3'd4 || o_rdy[0] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL full_ignored level=%0d ready=%b want level=4 ready=0", o_lvl[0], o_rdy[0]);
                end
            end
            for (int d = 0; d < 3; d++) begin
                if (o_done[d] === 1'b1) n_done[d]++;
                n_cmp++;
                if (obs_vec(d) !== exp_vec(d)) begin
                    n_fail++;
                    $display("FAIL full_line dut%0d t=%0t got=%b want=%b", d, $time, obs_vec(d), exp_vec(d));
                end
            end
        end
        for (int d = 0; d < 3; d++) begin
            vin[d] = 1'b0;
            n_cmp++;
            if (n_done[d] != 5) begin n_fail++; $display("FAIL full_frames dut%0d got=%0d want=5", d, n_done[d]); end
        end
    endtask

    task automatic test_random_traffic();
        for (int c = 0; c < 1800; c++) begin
            for (int d = 0; d < 3; d++) begin
                vin[d] = (c < 1500) && ($urandom_range(0, 5) == 0);
                din[d] = 9'($urandom);
            end
            @(posedge clock); @(negedge clock);
            for (int d = 0; d < 3; d++) begin
                n_cmp++;
                if (obs_vec(d) !== exp_vec(d)) begin
                    n_fail++;
                    $display("FAIL random_line dut%0d t=%0t got=%b want=%b", d, $time, obs_vec(d), exp_vec(d));
                end
            end
        end
        for (int d = 0; d < 3; d++) vin[d] = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        int act;
        int n_done;
        bit reached;
        act = 0; reached = 1'b0;
        for (int c = 0; c < 60 && !reached; c++) begin
            vin[0] = (c < 3);
            din[0] = 9'($urandom);
            @(posedge clock); @(negedge clock);
            if (o_at[0] === 1'b1) act++;
            if (act == 17) reached = 1'b1;
        end
        vin[0] = 1'b0;
        n_cmp++;
        if (!reached) begin n_fail++; $display("FAIL midframe_timeout active_clocks=%0d want=17", act); end
        reset_n = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            n_cmp++;
            if (obs_vec(d) !== 7'b1001000) begin
                n_fail++;
                $display("FAIL midframe_reset dut%0d got=%b want=%b", d, obs_vec(d), 7'b1001000);
            end
        end
        for (int c = 0; c < 3; c++) begin
            @(posedge clock); @(negedge clock);
            n_cmp++;
            if (obs_vec(0) !== 7'b1001000) begin
                n_fail++;
                $display("FAIL midframe_hold got=%b want=%b", obs_vec(0), 7'b1001000);
            end
        end
        reset_n = 1'b1;
        act = 0; n_done = 0;
        din[0] = 9'h05A;
        for (int c = 0; c < 50; c++) begin
            vin[0] = (c == 0);
            @(posedge clock); @(negedge clock);
            if (o_at[0] === 1'b1) act++;
            if (o_done[0] === 1'b1) n_done++;
            for (int d = 0; d < 3; d++) begin
                n_cmp++;
                if (obs_vec(d) !== exp_vec(d)) begin
                    n_fail++;
                    $display("FAIL post_reset_line dut%0d t=%0t got=%b want=%b", d, $time, obs_vec(d), exp_vec(d));
                end
            end
        end
        vin[0] = 1'b0;
        n_cmp++;
        if (act != 40 || n_done != 1) begin
            n_fail++;
            $display("FAIL post_reset_frame len=%0d dones=%0d want len=40 dones=1", act, n_done);
        end
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin vin[d] = 1'b0; din[d] = '0; end
        test_reset();
        test_basic_frame();
        test_fill_drain();
        test_full_ignore();
        test_random_traffic();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
